// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt scheduler: injection FSM encoding and
// the idle instruction word.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INJECT = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned GAP_W    = 4;

endpackage

// File: rtl/irq_fifo.sv
// Synchronous FIFO holding queued interrupt instruction words; pointers wrap
// naturally because DEPTH is a power of two.
module irq_fifo
    import irq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    // Pointer, storage and occupancy update; push/pop are ignored when they
    // would over- or under-run the queue.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        push_ok_s = push && (count_q < CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_q != '0);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/irq_scheduler.sv
// Round-robin collection of interrupt requests into a FIFO and paced injection
// of the queued words into the processor's interrupt_instruction input.
module irq_scheduler
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP        = 3,
    parameter logic [31:0] NOP        = NOP_WORD
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [32*NUM_SRC-1:0]         src_instr,
    output logic [NUM_SRC-1:0]            src_ack,
    input  logic                          enable,
    input  logic                          clear_overflow,
    output logic [31:0]                   interrupt_instruction,
    output logic                          inject_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    irq_state_e         state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;

    logic [PTR_W:0]     pick_s;
    logic               grant_found_s, fifo_full_s, push_s, launch_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [31:0]        push_word_s, head_s;
    logic [CNT_W-1:0]   count_s;

    // Returns {found, index}; the eligible source closest to ptr (upwards, wrapping) wins.
    function automatic logic [PTR_W:0] rr_pick(input logic [NUM_SRC-1:0] elig,
                                               input logic [PTR_W-1:0]   ptr);
        logic             found;
        logic [PTR_W-1:0] sel;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        sel   = ptr;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % int'(NUM_SRC));
            if (elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    // Arbitration, acknowledge generation and sticky overflow tracking
    always_comb begin
        pick_s        = rr_pick(src_req & ~ack_q, rr_ptr_q);
        grant_found_s = pick_s[PTR_W];
        grant_idx_s   = pick_s[PTR_W-1:0];
        fifo_full_s   = (count_s == CNT_W'(FIFO_DEPTH));
        push_s        = grant_found_s && !fifo_full_s;
        push_word_s   = src_instr[32*grant_idx_s +: 32];
        ack_d         = '0;
        rr_ptr_d      = rr_ptr_q;
        if (push_s) begin
            ack_d    = NUM_SRC'(1) << grant_idx_s;
            rr_ptr_d = (grant_idx_s == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            ack_d    = '0;
            rr_ptr_d = rr_ptr_q;
        end
        if (grant_found_s && fifo_full_s) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Arbiter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q      <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            ack_q      <= ack_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    irq_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (launch_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Injection FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next state: INJECT plus the GAP cycles span GAP cycles of NOP before IDLE can relaunch.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d = ST_INJECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INJECT: begin
                if (GAP <= 1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_W'(GAP);
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q <= GAP_W'(2)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // FSM outputs: launch pops the FIFO head onto the instruction bus
    always_comb begin
        launch_s = (state_q == ST_IDLE) && enable && (count_s != '0);
        if (launch_s) begin
            instr_d = head_s;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    // Registered injection outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign src_ack               = ack_q;
    assign interrupt_instruction = instr_q;
    assign inject_valid          = valid_q;
    assign fifo_count            = count_s;
    assign overflow              = overflow_q;

endmodule
